// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with two write ports, two
// registered read ports with write-to-read bypass, and a per-register busy
// scoreboard for decode-stage hazard detection.
// Optional feature macro: REG_ZERO_HARDWIRE_EN (address 0 reads as zero,
// ignores writes and never becomes busy).
module reg_file_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg_addr1,
    input  logic [ADDR_W-1:0] reg_addr2,
    input  logic              reg_rd_en,
    output logic [DATA_W-1:0] reg_out_1,
    output logic [DATA_W-1:0] reg_out_2,
    output logic              reg_busy_1,
    output logic              reg_busy_2,
    input  logic              reg_wr,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [DATA_W-1:0] reg_din,
    input  logic              reg_wr_b,
    input  logic [ADDR_W-1:0] reg_wr_addr_b,
    input  logic [DATA_W-1:0] reg_din_b,
    input  logic              reg_busy_set,
    input  logic [ADDR_W-1:0] reg_busy_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              wr_a_ok;
    logic              wr_b_ok;
    logic              set_ok;
    logic [DATA_W-1:0] val_1;
    logic [DATA_W-1:0] val_2;

    // Qualified write/issue enables; with address 0 hardwired, every path into
    // entry 0 is blocked here, so regs[0] stays 0 and bypass never returns
    // anything else for it.
    always_comb begin
`ifdef REG_ZERO_HARDWIRE_EN
        wr_a_ok = reg_wr       && (reg_wr_addr   != '0);
        wr_b_ok = reg_wr_b     && (reg_wr_addr_b != '0);
        set_ok  = reg_busy_set && (reg_busy_addr != '0);
`else
        wr_a_ok = reg_wr;
        wr_b_ok = reg_wr_b;
        set_ok  = reg_busy_set;
`endif
    end

    // Read value with bypass: port B data, then port A data, then storage.
    always_comb begin
        val_1 = regs[reg_addr1];
        if (wr_a_ok && (reg_wr_addr == reg_addr1))
            val_1 = reg_din;
        if (wr_b_ok && (reg_wr_addr_b == reg_addr1))
            val_1 = reg_din_b;

        val_2 = regs[reg_addr2];
        if (wr_a_ok && (reg_wr_addr == reg_addr2))
            val_2 = reg_din;
        if (wr_b_ok && (reg_wr_addr_b == reg_addr2))
            val_2 = reg_din_b;
    end

    // Register array update; port B is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            if (wr_a_ok && !(wr_b_ok && (reg_wr_addr_b == reg_wr_addr)))
                regs[reg_wr_addr] <= reg_din;
            if (wr_b_ok)
                regs[reg_wr_addr_b] <= reg_din_b;
        end
    end

    // Scoreboard: writes retire the pending producer; a same-edge issue re-marks it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (set_ok && (reg_busy_addr == ADDR_W'(i)))
                    busy[i] <= 1'b1;
                else if ((wr_a_ok && (reg_wr_addr   == ADDR_W'(i))) ||
                         (wr_b_ok && (reg_wr_addr_b == ADDR_W'(i))))
                    busy[i] <= 1'b0;
            end
        end
    end

    // Registered read ports; hold their value while reg_rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_out_1 <= '0;
            reg_out_2 <= '0;
        end else if (reg_rd_en) begin
            reg_out_1 <= val_1;
            reg_out_2 <= val_2;
        end
    end

    assign reg_busy_1 = busy[reg_addr1];
    assign reg_busy_2 = busy[reg_addr2];

endmodule

// File: tb/tb_reg_file_param.sv
// Testbench for reg_file_param: directed vectors with literal expectations,
// plus a behavioural model compared against the outputs every cycle.
// Honours REG_ZERO_HARDWIRE_EN when defined for the build.
module tb_reg_file_param;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] reg_addr1, reg_addr2;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_out_1, reg_out_2;
    logic              reg_busy_1, reg_busy_2;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [DATA_W-1:0] reg_din;
    logic              reg_wr_b;
    logic [ADDR_W-1:0] reg_wr_addr_b;
    logic [DATA_W-1:0] reg_din_b;
    logic              reg_busy_set;
    logic [ADDR_W-1:0] reg_busy_addr;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_addr1     (reg_addr1),
        .reg_addr2     (reg_addr2),
        .reg_rd_en     (reg_rd_en),
        .reg_out_1     (reg_out_1),
        .reg_out_2     (reg_out_2),
        .reg_busy_1    (reg_busy_1),
        .reg_busy_2    (reg_busy_2),
        .reg_wr        (reg_wr),
        .reg_wr_addr   (reg_wr_addr),
        .reg_din       (reg_din),
        .reg_wr_b      (reg_wr_b),
        .reg_wr_addr_b (reg_wr_addr_b),
        .reg_din_b     (reg_din_b),
        .reg_busy_set  (reg_busy_set),
        .reg_busy_addr (reg_busy_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_mem  [DEPTH];
    bit                m_busy [DEPTH];
    logic [DATA_W-1:0] m_out1, m_out2;

    function automatic bit addr_live(input logic [ADDR_W-1:0] a);
`ifdef REG_ZERO_HARDWIRE_EN
        return a != 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] m_value(input logic [ADDR_W-1:0] a);
        if (!addr_live(a))                   return '0;
        if (reg_wr_b && reg_wr_addr_b == a)  return reg_din_b;
        if (reg_wr   && reg_wr_addr   == a)  return reg_din;
        return m_mem[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 0;
            end
            m_out1 = '0;
            m_out2 = '0;
        end else begin
            logic [DATA_W-1:0] v1, v2;
            v1 = m_value(reg_addr1);
            v2 = m_value(reg_addr2);
            if (reg_rd_en) begin
                m_out1 = v1;
                m_out2 = v2;
            end
            if (reg_wr && addr_live(reg_wr_addr)) begin
                m_mem[reg_wr_addr]  = reg_din;
                m_busy[reg_wr_addr] = 0;
            end
            if (reg_wr_b && addr_live(reg_wr_addr_b)) begin
                m_mem[reg_wr_addr_b]  = reg_din_b;
                m_busy[reg_wr_addr_b] = 0;
            end
            if (reg_busy_set && addr_live(reg_busy_addr))
                m_busy[reg_busy_addr] = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model out1",  32'(reg_out_1),  32'(m_out1));
            chk("model out2",  32'(reg_out_2),  32'(m_out2));
            chk("model busy1", 32'(reg_busy_1), 32'(m_busy[reg_addr1]));
            chk("model busy2", 32'(reg_busy_2), 32'(m_busy[reg_addr2]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_wr       = 0;
        reg_wr_b     = 0;
        reg_busy_set = 0;
        reg_rd_en    = 0;
    endtask

    initial begin
        rst_n = 0;
        reg_addr1 = '0; reg_addr2 = '0; reg_rd_en = 0;
        reg_wr = 0; reg_wr_addr = '0; reg_din = '0;
        reg_wr_b = 0; reg_wr_addr_b = '0; reg_din_b = '0;
        reg_busy_set = 0; reg_busy_addr = '0;
        tick(); tick();
        rst_n = 1;
        chk_en = 1;
        tick();

        // Dirty some state, then reset mid-cycle
        reg_wr = 1; reg_wr_addr = 5'd3; reg_din = 16'hABCD;
        reg_busy_set = 1; reg_busy_addr = 5'd8;
        tick();
        idle();
        #3 rst_n = 0;
        #2 rst_n = 1;

        // Reset value
        reg_addr1 = 5'd3; reg_addr2 = 5'd8; reg_rd_en = 1;
        tick();
        chk("reset out1",  32'(reg_out_1), 32'h0);
        chk("reset out2",  32'(reg_out_2), 32'h0);
        chk("reset busy1", 32'(reg_busy_1), 32'h0);
        chk("reset busy2", 32'(reg_busy_2), 32'h0);

        // Basic write then read
        idle();
        reg_wr = 1; reg_wr_addr = 5'd3; reg_din = 16'h0F0F;
        tick();
        idle();
        reg_rd_en = 1; reg_addr1 = 5'd3; reg_addr2 = 5'd8;
        tick();
        chk("basic out1", 32'(reg_out_1), 32'h0F0F);
        chk("basic out2", 32'(reg_out_2), 32'h0);

        // Same-cycle double write with bypass
        reg_wr = 1;   reg_wr_addr = 5'd5;   reg_din = 16'h1111;
        reg_wr_b = 1; reg_wr_addr_b = 5'd5; reg_din_b = 16'h2222;
        reg_addr1 = 5'd5;
        tick();
        chk("bypass conflict", 32'(reg_out_1), 32'h2222);
        idle();
        reg_rd_en = 1;
        tick();
        chk("stored conflict", 32'(reg_out_1), 32'h2222);

        // Read hold
        idle();
        reg_addr1 = 5'd9; reg_addr2 = 5'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold out1", 32'(reg_out_1), 32'h2222);
            chk("hold out2", 32'(reg_out_2), 32'h0);
        end

        // Scoreboard
        reg_busy_set = 1; reg_busy_addr = 5'd7; reg_addr1 = 5'd7;
        tick();
        chk("busy set", 32'(reg_busy_1), 32'h1);
        idle();
        reg_wr_b = 1; reg_wr_addr_b = 5'd7; reg_din_b = 16'h7777;
        tick();
        chk("busy clear B", 32'(reg_busy_1), 32'h0);
        idle();
        reg_busy_set = 1; reg_busy_addr = 5'd7;
        reg_wr = 1; reg_wr_addr = 5'd7; reg_din = 16'h7070;
        tick();
        chk("busy set wins", 32'(reg_busy_1), 32'h1);
        idle();
        reg_wr = 1; reg_wr_addr = 5'd7; reg_din = 16'h0707;
        tick();
        chk("busy clear A", 32'(reg_busy_1), 32'h0);

        // Address 0 behaviour
        idle();
        reg_wr = 1; reg_wr_addr = 5'd0; reg_din = 16'hFFFF;
        reg_busy_set = 1; reg_busy_addr = 5'd0;
        tick();
        idle();
        reg_rd_en = 1; reg_addr1 = 5'd0;
        tick();
`ifdef REG_ZERO_HARDWIRE_EN
        chk("zero read",  32'(reg_out_1),  32'h0);
        chk("zero busy",  32'(reg_busy_1), 32'h0);
`else
        chk("zero read",  32'(reg_out_1),  32'hFFFF);
        chk("zero busy",  32'(reg_busy_1), 32'h1);
`endif
        reg_wr_b = 1; reg_wr_addr_b = 5'd0; reg_din_b = 16'h1234;
        tick();
`ifdef REG_ZERO_HARDWIRE_EN
        chk("zero bypass", 32'(reg_out_1), 32'h0);
`else
        chk("zero bypass", 32'(reg_out_1), 32'h1234);
`endif

        // Mixed traffic on a narrow address window, checked by the model
        for (int n = 0; n < 400; n++) begin
            reg_addr1     = ADDR_W'($urandom_range(0, 7));
            reg_addr2     = ADDR_W'($urandom_range(0, 7));
            reg_rd_en     = ($urandom_range(0, 3) != 0);
            reg_wr        = $urandom_range(0, 1) == 1;
            reg_wr_addr   = ADDR_W'($urandom_range(0, 7));
            reg_din       = DATA_W'($urandom);
            reg_wr_b      = $urandom_range(0, 2) == 0;
            reg_wr_addr_b = ADDR_W'($urandom_range(0, 7));
            reg_din_b     = DATA_W'($urandom);
            reg_busy_set  = $urandom_range(0, 1) == 1;
            reg_busy_addr = ADDR_W'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
